// File: rtl/spike_output_collector.sv
// Spike output collector: timestamps SNN time steps, queues non-zero spike
// vectors in a small show-ahead event FIFO for a host reader, and keeps
// saturating per-neuron spike counts plus a dropped-event counter.

// Saturating spike counter for a single output neuron.
module spike_counter_lane #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 system_clock,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    // Count spikes, holding at all-ones; clear wins over increment.
    always_ff @(posedge system_clock or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (inc && (count != {CNT_WIDTH{1'b1}}))
            count <= count + CNT_WIDTH'(1);
    end

endmodule

module spike_output_collector #(
    parameter int N_OUT     = 2,
    parameter int TS_WIDTH  = 6,
    parameter int DEPTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                       system_clock,
    input  logic                       rst_n,
    input  logic                       step_valid,
    input  logic [N_OUT-1:0]           output_spikes,
    input  logic                       clear,
    output logic                       evt_valid,
    output logic [TS_WIDTH+N_OUT-1:0]  evt_data,
    input  logic                       evt_ready,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [N_OUT*CNT_WIDTH-1:0] spike_counts,
    output logic [TS_WIDTH-1:0]        timestamp,
    output logic                       overflow,
    output logic [CNT_WIDTH-1:0]       drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = TS_WIDTH + N_OUT;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DEPTH-1:0][EW-1:0] mem;
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic                     push_req;
    logic                     pop;
    logic                     push;
    logic                     drop;

    // Head of the FIFO is presented straight from registers (show-ahead).
    assign evt_valid = (fifo_count != '0);
    assign evt_data  = mem[rd_ptr];

    // A full FIFO still takes a push if the reader frees a slot this cycle.
    assign push_req = step_valid && (output_spikes != '0);
    assign pop      = evt_valid && evt_ready;
    assign push     = push_req && ((fifo_count != FULL) || pop);
    assign drop     = push_req && !push;

    // Event storage; zeroed on reset/clear so evt_data reads 0 when empty.
    always_ff @(posedge system_clock or negedge rst_n) begin
        if (!rst_n)
            mem <= '0;
        else if (clear)
            mem <= '0;
        else if (push)
            mem[wr_ptr] <= {timestamp, output_spikes};
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge system_clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                fifo_count <= fifo_count + CW'(1);
            else if (pop && !push)
                fifo_count <= fifo_count - CW'(1);
        end
    end

    // Step index; an event pushed this cycle carries the pre-increment value.
    always_ff @(posedge system_clock or negedge rst_n) begin
        if (!rst_n)
            timestamp <= '0;
        else if (clear)
            timestamp <= '0;
        else if (step_valid)
            timestamp <= timestamp + TS_WIDTH'(1);
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge system_clock or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != {CNT_WIDTH{1'b1}})
                drop_count <= drop_count + CNT_WIDTH'(1);
        end
    end

    // One saturating counter per neuron; counts even when the push is dropped.
    for (genvar i = 0; i < N_OUT; i++) begin : g_lane
        spike_counter_lane #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_lane (
            .system_clock (system_clock),
            .rst_n        (rst_n),
            .clear        (clear),
            .inc          (step_valid && output_spikes[i]),
            .count        (spike_counts[i*CNT_WIDTH +: CNT_WIDTH])
        );
    end

endmodule

// File: tb/tb_spike_output_collector.sv
// Self-checking bench for spike_output_collector: a table of step vectors with
// expected timestamp/occupancy, a scoreboard queue for FIFO contents, and
// hand-written sequences for overflow, wrap, saturation, clear and reset.
module tb_spike_output_collector;

    localparam int N_OUT = 2, TS_WIDTH = 6, DEPTH = 8, CNT_WIDTH = 8;
    localparam int EW = TS_WIDTH + N_OUT;

    logic                       system_clock = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       step_valid = 1'b0;
    logic [N_OUT-1:0]           output_spikes = '0;
    logic                       clear = 1'b0;
    logic                       evt_valid;
    logic [EW-1:0]              evt_data;
    logic                       evt_ready = 1'b0;
    logic [$clog2(DEPTH):0]     fifo_count;
    logic [N_OUT*CNT_WIDTH-1:0] spike_counts;
    logic [TS_WIDTH-1:0]        timestamp;
    logic                       overflow;
    logic [CNT_WIDTH-1:0]       drop_count;

    spike_output_collector #(
        .N_OUT(N_OUT), .TS_WIDTH(TS_WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .system_clock  (system_clock),
        .rst_n         (rst_n),
        .step_valid    (step_valid),
        .output_spikes (output_spikes),
        .clear         (clear),
        .evt_valid     (evt_valid),
        .evt_data      (evt_data),
        .evt_ready     (evt_ready),
        .fifo_count    (fifo_count),
        .spike_counts  (spike_counts),
        .timestamp     (timestamp),
        .overflow      (overflow),
        .drop_count    (drop_count)
    );

    always #5 system_clock = ~system_clock;

    int checks = 0;
    int errors = 0;

    // Reference state.
    logic [EW-1:0]        sb[$];
    logic [TS_WIDTH-1:0]  m_ts;
    int                   m_cnt[N_OUT];
    int                   m_drop;
    bit                   m_ovf;

    typedef struct {
        bit       st;
        bit [1:0] sp;
        bit       rd;
        int       exp_ts;
        int       exp_fc;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_ts = '0;
        for (int i = 0; i < N_OUT; i++) m_cnt[i] = 0;
        m_drop = 0;
        m_ovf = 1'b0;
    endtask

    task automatic check_state();
        chk("timestamp", int'(timestamp), int'(m_ts));
        chk("fifo_count", int'(fifo_count), sb.size());
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("drop_count", int'(drop_count), m_drop);
        for (int i = 0; i < N_OUT; i++)
            chk($sformatf("spike_count%0d", i),
                int'(spike_counts[i*CNT_WIDTH +: CNT_WIDTH]), m_cnt[i]);
    endtask

    // Drive one cycle (called at posedge+1). Scoreboard and model are updated
    // at the negedge, just before the edge that consumes these inputs.
    task automatic drive_cycle(input bit st, input bit [1:0] sp, input bit rd, input bit cl,
                               input bit full_check);
        bit pop, req, acc;
        step_valid = st; output_spikes = sp; evt_ready = rd; clear = cl;
        @(negedge system_clock);
        chk("evt_valid", int'(evt_valid), int'(sb.size() != 0));
        if (cl) begin
            model_reset();
        end else begin
            pop = (sb.size() != 0) && rd;
            if (pop) begin
                chk("evt_data", int'(evt_data), int'(sb[0]));
                void'(sb.pop_front());
            end
            req = st && (sp != 2'b00);
            acc = req && ((sb.size() < DEPTH) || pop);
            if (acc) sb.push_back({m_ts, sp});
            if (req && !acc) begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
            if (st) begin
                m_ts = m_ts + 1'b1;
                for (int i = 0; i < N_OUT; i++)
                    if (sp[i] && m_cnt[i] < 255) m_cnt[i]++;
            end
        end
        @(posedge system_clock);
        #1;
        step_valid = 1'b0; output_spikes = '0; clear = 1'b0; evt_ready = 1'b0;
        if (full_check) check_state();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            drive_cycle(1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
            n++;
        end
        chk("drain_done", sb.size(), 0);
        chk("drain_evt_valid", int'(evt_valid), 0);
    endtask

    vec_t tbl[3];

    initial begin
        model_reset();

        // Reset then idle.
        rst_n = 1'b0;
        repeat (3) @(posedge system_clock);
        #1 rst_n = 1'b1;
        chk("rst_evt_valid", int'(evt_valid), 0);
        chk("rst_evt_data", int'(evt_data), 0);
        chk("rst_fifo_count", int'(fifo_count), 0);
        chk("rst_spike_counts", int'(spike_counts), 0);
        chk("rst_timestamp", int'(timestamp), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_drop_count", int'(drop_count), 0);
        drive_cycle(1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
        chk("idle_ready_fifo", int'(fifo_count), 0);

        // Table: steps 00, 10, 01 with the reader stalled.
        tbl[0] = '{st: 1'b1, sp: 2'b00, rd: 1'b0, exp_ts: 1, exp_fc: 0};
        tbl[1] = '{st: 1'b1, sp: 2'b10, rd: 1'b0, exp_ts: 2, exp_fc: 1};
        tbl[2] = '{st: 1'b1, sp: 2'b01, rd: 1'b0, exp_ts: 3, exp_fc: 2};
        for (int i = 0; i < 3; i++) begin
            drive_cycle(tbl[i].st, tbl[i].sp, tbl[i].rd, 1'b0, 1'b1);
            chk($sformatf("tbl%0d_ts", i), int'(timestamp), tbl[i].exp_ts);
            chk($sformatf("tbl%0d_fc", i), int'(fifo_count), tbl[i].exp_fc);
        end
        chk("head_0x06", int'(evt_data), 8'h06);
        chk("counts_11", int'(spike_counts), 16'h0101);
        drive_cycle(1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
        chk("head_0x09", int'(evt_data), 8'h09);
        drain(10);

        // Overflow: 10 steps of 11 with reader stalled.
        drive_cycle(1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) drive_cycle(1'b1, 2'b11, 1'b0, 1'b0, 1'b1);
        chk("ovf_fifo_count", int'(fifo_count), 8);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_drop_count", int'(drop_count), 2);
        chk("ovf_counts", int'(spike_counts), 16'h0a0a);
        chk("ovf_head_ts0", int'(evt_data), 8'h03);

        // Full with simultaneous push and pop.
        drive_cycle(1'b1, 2'b11, 1'b1, 1'b0, 1'b1);
        chk("full_pp_fifo_count", int'(fifo_count), 8);
        chk("full_pp_drop_count", int'(drop_count), 2);
        drain(20);

        // Timestamp wrap: 64 steps return to the same value.
        drive_cycle(1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 64; i++) drive_cycle(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("wrap_timestamp", int'(timestamp), 0);

        // Saturation: 300 steps of 01 with the reader draining.
        for (int i = 0; i < 300; i++) drive_cycle(1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
        check_state();
        chk("sat_count0", int'(spike_counts[7:0]), 255);
        chk("sat_count1", int'(spike_counts[15:8]), 0);
        chk("sat_no_drop", int'(drop_count), 0);
        drain(20);

        // Clear priority over step_valid and evt_ready.
        drive_cycle(1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 2'b11, 1'b1, 1'b1, 1'b1);
        chk("clr_fifo_count", int'(fifo_count), 0);
        chk("clr_evt_valid", int'(evt_valid), 0);
        chk("clr_timestamp", int'(timestamp), 0);
        chk("clr_counts", int'(spike_counts), 0);
        chk("clr_evt_data", int'(evt_data), 0);

        // Asynchronous reset mid-drain.
        drive_cycle(1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
        evt_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_evt_valid", int'(evt_valid), 0);
        chk("arst_fifo_count", int'(fifo_count), 0);
        chk("arst_timestamp", int'(timestamp), 0);
        chk("arst_counts", int'(spike_counts), 0);
        model_reset();
        evt_ready = 1'b0;
        @(posedge system_clock);
        #1 rst_n = 1'b1;
        drive_cycle(1'b0, 2'b00, 1'b1, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
